tcp_tx_responder: RTL
=====================

TCP_TX_RESPONDER -- requirements
Module: tcp_tx_responder

Interface
REQ-001 Parameter DATA_W, 512, data stream width in bits; keep width is DATA_W/8.
REQ-002 Parameter SESS_BITS, 4, number of session-index bits checked; NSESS = 2^SESS_BITS.
REQ-003 Parameter BUF_BYTES, 65536, TX buffer capacity in bytes; the space counter is 32 bits.
REQ-004 Ports:
- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_tx_meta_tvalid/tready/tdata  in/out/in  1/1/32  send request; [15:0] session, [31:16] length in bytes.
- m_tx_stat_tvalid/tready/tdata  out/in/out  1/1/64  response; [15:0] session, [31:16] length, [61:32] remaining space, [63:62] error.
- s_tx_data_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  payload from the initiator.
- m_net_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  forwarded payload.
- session_open  in  NSESS  bit i set means session i is open.
- credit_valid/credit_bytes  in/in  1/16  acknowledged bytes returned to the buffer.
- space  out  32  current free buffer bytes.
- len_err  out  1  one-cycle pulse on a payload length mismatch.
- len_err_cnt  out  16  count of length mismatches.

Function
REQ-005 The FSM SHALL have three states: IDLE, STAT, DATA.
REQ-006 In IDLE, s_tx_meta_tready SHALL be 1; a meta handshake SHALL latch session and length and move to STAT on the next cycle.
REQ-007 The error code SHALL be computed from the latched values:
- 3 if length==0.
- else 1 if session[15:SESS_BITS]!=0 or session_open[session[SESS_BITS-1:0]]==0.
- else 2 if length>space.
- else 0.
- Priority is 3 > 1 > 2.
REQ-008 In STAT, m_tx_stat_tvalid SHALL be 1 with tdata carrying the echoed session, echoed length, error code, and remaining space.
- Remaining space is the post-decrement value when error==0, otherwise the current space.
- tdata SHALL remain stable until tready.
REQ-009 On the stat handshake, the block SHALL go to DATA if error==0, else to IDLE. Space SHALL be decremented by length in the same cycle only when error==0.
REQ-010 In DATA, the data path SHALL be combinational pass-through: m_net_* = s_tx_data_*, and s_tx_data_tready = m_net_tready. In all other states s_tx_data_tready and m_net_tvalid SHALL be 0.
REQ-011 In DATA, the block SHALL accumulate accepted bytes (popcount of tkeep) in a 16-bit counter. The counter SHALL clear on entry to DATA.
REQ-012 On the accepted beat with tlast=1, the block SHALL return to IDLE.
- If the total including that beat differs from the latched length, len_err SHALL pulse on the following cycle and len_err_cnt SHALL increment, saturating at 0xFFFF.
REQ-013 Meta SHALL NOT be accepted outside IDLE; at most one transfer is outstanding.
REQ-014 When credit_valid=1, space SHALL increase by credit_bytes, saturating at BUF_BYTES.
REQ-015 A credit and a stat-handshake decrement in the same cycle SHALL both apply: space_next = min(space - length + credit_bytes, BUF_BYTES).
REQ-016 Latency SHALL be as follows:
- meta accept at cycle n gives stat valid at n+1;
- stat accept with error==0 enables data acceptance from the next cycle.
REQ-017 session_open SHALL be sampled in STAT (combinationally). A change between meta accept and stat accept SHALL be reflected in the response.

Reset
REQ-018 While aresetn=0, outputs SHALL be:
- state=IDLE, space=BUF_BYTES, len_err_cnt=0, len_err=0;
- m_tx_stat_tvalid=0, s_tx_data_tready=0, m_net_tvalid=0, s_tx_meta_tready=0.
s_tx_meta_tready SHALL rise on the first clock after deassertion.
REQ-019 Reset asserted mid-DATA SHALL abandon the transfer with no len_err and no counter change. Space SHALL NOT be restored except by reset to BUF_BYTES.

Verification
REQ-020 Bench SHALL cover the scenarios below (DATA_W=512, BUF_BYTES=65536).
- Session 3 open, meta {3,128} -> stat error 0, space 65408; two full beats, tlast on the second -> forwarded unchanged, no len_err, back in IDLE.
- Session 5 closed, meta {5,64} -> stat error 1, space 65536, returns to IDLE; a data beat presented afterwards is not accepted.
- Meta {3,0} -> error 3. Session 0x0013 -> error 1. Space 100 with meta {3,200} -> error 2, space unchanged.
- Meta {3,100}, then one beat with tkeep=all-ones and tlast -> len_err pulse, len_err_cnt=1.
- Space 65408 with credit 200 coinciding with a stat handshake for length 64 -> space 65536 (saturated). m_tx_stat_tready held low 5 cycles -> stat tdata stable throughout.
- aresetn pulsed low mid-DATA -> all outputs at reset values, space=65536, next meta accepted normally.

Source files
------------

// File: rtl/tcp_tx_responder.sv
// TCP transmit responder: validates a send request against session state and buffer space,
// answers with a status word, then forwards the payload while checking its byte count.
module tcp_tx_responder #(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned SESS_BITS = 4,
  parameter int unsigned BUF_BYTES = 65536
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_tx_meta_tvalid,
  output logic                    s_tx_meta_tready,
  input  logic [31:0]             s_tx_meta_tdata,
  output logic                    m_tx_stat_tvalid,
  input  logic                    m_tx_stat_tready,
  output logic [63:0]             m_tx_stat_tdata,
  input  logic                    s_tx_data_tvalid,
  output logic                    s_tx_data_tready,
  input  logic [DATA_W-1:0]       s_tx_data_tdata,
  input  logic [DATA_W/8-1:0]     s_tx_data_tkeep,
  input  logic                    s_tx_data_tlast,
  output logic                    m_net_tvalid,
  input  logic                    m_net_tready,
  output logic [DATA_W-1:0]       m_net_tdata,
  output logic [DATA_W/8-1:0]     m_net_tkeep,
  output logic                    m_net_tlast,
  input  logic [(1<<SESS_BITS)-1:0] session_open,
  input  logic                    credit_valid,
  input  logic [15:0]             credit_bytes,
  output logic [31:0]             space,
  output logic                    len_err,
  output logic [15:0]             len_err_cnt
);

  localparam int unsigned KeepW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StStat, StData} state_e;

  state_e      r_state;
  logic        r_alive;
  logic [15:0] r_sess;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [15:0] r_err_cnt;
  logic        r_len_err;
  logic [31:0] r_space;

  logic [1:0]  w_err;
  logic        w_ok;
  logic [31:0] w_remain;
  logic        w_stat_hs;
  logic [32:0] w_sum;
  logic [31:0] w_space_d;
  logic [15:0] w_keep_cnt;
  logic [15:0] w_total;
  logic        w_beat;

  // Error is evaluated live in STAT so session_open and credits are reflected in the answer.
  always_comb begin
    w_err = 2'd0;
    if (r_len == 16'd0) begin
      w_err = 2'd3;
    end else if ((r_sess[15:SESS_BITS] != '0) || !session_open[r_sess[SESS_BITS-1:0]]) begin
      w_err = 2'd1;
    end else if ({16'd0, r_len} > r_space) begin
      w_err = 2'd2;
    end
  end

  assign w_ok      = (w_err == 2'd0);
  assign w_remain  = w_ok ? (r_space - {16'd0, r_len}) : r_space;
  assign w_stat_hs = (r_state == StStat) && m_tx_stat_tready;

  always_comb begin
    w_sum = {1'b0, (w_stat_hs ? w_remain : r_space)};
    if (credit_valid) begin
      w_sum = w_sum + {17'd0, credit_bytes};
    end
    w_space_d = (w_sum > 33'(BUF_BYTES)) ? 32'(BUF_BYTES) : w_sum[31:0];
  end

  always_comb begin
    w_keep_cnt = 16'd0;
    for (int i = 0; i < KeepW; i++) begin
      w_keep_cnt = w_keep_cnt + {15'd0, s_tx_data_tkeep[i]};
    end
  end

  assign w_beat  = (r_state == StData) && s_tx_data_tvalid && m_net_tready;
  assign w_total = r_cnt + w_keep_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= StIdle;
      r_alive   <= 1'b0;
      r_sess    <= 16'd0;
      r_len     <= 16'd0;
      r_cnt     <= 16'd0;
      r_err_cnt <= 16'd0;
      r_len_err <= 1'b0;
      r_space   <= 32'(BUF_BYTES);
    end else begin
      r_alive   <= 1'b1;
      r_space   <= w_space_d;
      r_len_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (s_tx_meta_tvalid && r_alive) begin
            r_sess  <= s_tx_meta_tdata[15:0];
            r_len   <= s_tx_meta_tdata[31:16];
            r_state <= StStat;
          end
        end
        StStat: begin
          if (m_tx_stat_tready) begin
            r_cnt   <= 16'd0;
            r_state <= w_ok ? StData : StIdle;
          end
        end
        StData: begin
          if (w_beat) begin
            r_cnt <= w_total;
            if (s_tx_data_tlast) begin
              r_state <= StIdle;
              if (w_total != r_len) begin
                r_len_err <= 1'b1;
                if (r_err_cnt != 16'hFFFF) begin
                  r_err_cnt <= r_err_cnt + 16'd1;
                end
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_tx_meta_tready = r_alive && (r_state == StIdle);
  assign m_tx_stat_tvalid = (r_state == StStat);
  assign m_tx_stat_tdata  = {w_err, w_remain[29:0], r_len, r_sess};

  assign s_tx_data_tready = (r_state == StData) && m_net_tready;
  assign m_net_tvalid     = (r_state == StData) && s_tx_data_tvalid;
  assign m_net_tdata      = s_tx_data_tdata;
  assign m_net_tkeep      = s_tx_data_tkeep;
  assign m_net_tlast      = s_tx_data_tlast;

  assign space       = r_space;
  assign len_err     = r_len_err;
  assign len_err_cnt = r_err_cnt;

endmodule
